// File: rtl/dual_rail_expect_sink_pkg.sv
// Shared definitions for the dual-rail channel sink (and its matching source).
//   state_e  : handshake FSM states
//   RAIL_0/1 : token values carried by rail d0 / rail d1
//   E_ACTIVE : asserted level of the channel enable/acknowledge
package dual_rail_expect_sink_pkg;

  typedef enum logic [0:0] {
    StWaitNeutral = 1'b0,
    StReady       = 1'b1
  } state_e;

  localparam logic RAIL_0   = 1'b0;
  localparam logic RAIL_1   = 1'b1;
  localparam logic E_ACTIVE = 1'b1;

  // Saturating increment used by error counters of any width up to 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
    return (val >= max) ? max : val + 32'd1;
  endfunction

endpackage

// File: rtl/dual_rail_expect_sink_if.sv
// 1-of-2 dual-rail four-phase channel.
//   d0, d1 : data rails (one-hot when valid, both low when neutral)
//   e      : enable/acknowledge from the sink, high = ready for data
// master = token source (prsim side), slave = token sink.
interface dual_rail_expect_sink_if;
  logic d0;
  logic d1;
  logic e;

  modport master (output d0, output d1, input e);
  modport slave  (input d0, input d1, output e);
endinterface

// File: rtl/dual_rail_expect_sink_sync2.sv
// Two-flop synchroniser for one asynchronous rail.
//   clk   : destination clock
//   reset : synchronous active-high clear of both flops
//   d     : asynchronous input
//   q     : synchronised output, two edges behind d
module dual_rail_expect_sink_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/dual_rail_expect_sink.sv
// Clocked sink for a 1-of-2 dual-rail four-phase channel. Acknowledges each
// token, compares it against EXPECT_SEQ and reports mismatches and protocol
// violations.
//   clk, reset : clock and synchronous active-high reset
//   ch         : dual-rail channel (slave side: d0/d1 in, e out)
//   stall      : holds off re-raising e while waiting for neutral
//   tok_valid  : one-cycle pulse per accepted token
//   tok_data   : value of the last accepted token
//   mismatch   : one-cycle pulse with tok_valid when token != expected
//   err_count  : saturating mismatch count
//   seq_idx    : index of the next expected token
//   done       : one-shot mode, all SEQ_LEN tokens received
//   overrun    : sticky, token received after done
//   proto_err  : sticky, both rails seen high together
module dual_rail_expect_sink
  import dual_rail_expect_sink_pkg::*;
#(
  parameter int unsigned SEQ_LEN    = 6,
  parameter logic [31:0] EXPECT_SEQ = 32'b000110,
  parameter bit          LOOP       = 1'b1,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  dual_rail_expect_sink_if.slave ch,
  input  logic                 stall,
  output logic                 tok_valid,
  output logic                 tok_data,
  output logic                 mismatch,
  output logic [ERR_W-1:0]     err_count,
  output logic [4:0]           seq_idx,
  output logic                 done,
  output logic                 overrun,
  output logic                 proto_err
);

  // Index is one bit wider than the port so one-shot mode can park at
  // SEQ_LEN == 32; in that corner seq_idx reads 0 and done disambiguates.
  localparam logic [5:0]       LAST_IDX = 6'(SEQ_LEN - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  logic s0;
  logic s1;

  dual_rail_expect_sink_sync2 u_sync_d0 (
    .clk   (clk),
    .reset (reset),
    .d     (ch.d0),
    .q     (s0)
  );

  dual_rail_expect_sink_sync2 u_sync_d1 (
    .clk   (clk),
    .reset (reset),
    .d     (ch.d1),
    .q     (s1)
  );

  // Reset clears the synchronisers, so their zeros are not a real view of
  // the rails until two edges have refilled them. Without this hold-off a
  // reset during a token (rail still high) would raise e straight away.
  logic [1:0] fill_q, fill_d;
  logic       sync_ok;

  state_e             state_q, state_d;
  logic               tok_valid_q, tok_valid_d;
  logic               tok_data_q, tok_data_d;
  logic               mismatch_q, mismatch_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [5:0]         idx_q, idx_d;
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;
  logic               proto_q, proto_d;

  assign sync_ok = (fill_q == 2'd2);
  assign fill_d  = sync_ok ? fill_q : fill_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    tok_valid_d = 1'b0;
    tok_data_d  = tok_data_q;
    mismatch_d  = 1'b0;
    err_d       = err_q;
    idx_d       = idx_q;
    done_d      = done_q;
    overrun_d   = overrun_q;
    proto_d     = proto_q;

    unique case (state_q)
      StWaitNeutral: begin
        if (sync_ok && !s0 && !s1 && !stall) begin
          state_d = StReady;
        end
      end
      StReady: begin
        if (s0 && s1) begin
          proto_d = 1'b1;
          state_d = StWaitNeutral;
        end else if (s0 ^ s1) begin
          state_d     = StWaitNeutral;
          tok_valid_d = 1'b1;
          tok_data_d  = s1 ? RAIL_1 : RAIL_0;
          if (done_q) begin
            // Past the end of a one-shot sequence: acknowledge, never compare.
            overrun_d = 1'b1;
          end else begin
            mismatch_d = (s1 != EXPECT_SEQ[idx_q[4:0]]);
            if (mismatch_d && (err_q != ERR_MAX)) begin
              err_d = err_q + ERR_W'(1);
            end
            if (LOOP) begin
              idx_d = (idx_q == LAST_IDX) ? 6'd0 : idx_q + 6'd1;
            end else begin
              idx_d = idx_q + 6'd1;
              if (idx_q == LAST_IDX) begin
                done_d = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = StWaitNeutral;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q      <= 2'd0;
      state_q     <= StWaitNeutral;
      tok_valid_q <= 1'b0;
      tok_data_q  <= 1'b0;
      mismatch_q  <= 1'b0;
      err_q       <= '0;
      idx_q       <= 6'd0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      proto_q     <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      state_q     <= state_d;
      tok_valid_q <= tok_valid_d;
      tok_data_q  <= tok_data_d;
      mismatch_q  <= mismatch_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      proto_q     <= proto_d;
    end
  end

  // e is a pure function of the registered state, so it is glitch-free.
  assign ch.e      = (state_q == StReady) ? E_ACTIVE : ~E_ACTIVE;
  assign tok_valid = tok_valid_q;
  assign tok_data  = tok_data_q;
  assign mismatch  = mismatch_q;
  assign err_count = err_q;
  assign seq_idx   = idx_q[4:0];
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign proto_err = proto_q;

endmodule

// File: tb/tb_dual_rail_expect_sink.sv
// Bench for dual_rail_expect_sink. Three instances share clk/reset:
//   0: LOOP=1, SEQ_LEN=6, EXPECT_SEQ=000110, ERR_W=8
//   1: LOOP=0, SEQ_LEN=3, EXPECT_SEQ=010,    ERR_W=8
//   2: LOOP=1, SEQ_LEN=1, EXPECT_SEQ=0,      ERR_W=2 (saturation)
module tb_dual_rail_expect_sink;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dual_rail_expect_sink_if if0 ();
  dual_rail_expect_sink_if if1 ();
  dual_rail_expect_sink_if if2 ();

  logic       d0_r [3];
  logic       d1_r [3];
  logic       st_r [3];
  logic       e_w  [3];
  logic       tv_w [3];
  logic       td_w [3];
  logic       mm_w [3];
  logic       dn_w [3];
  logic       ov_w [3];
  logic       pe_w [3];
  logic [4:0] si_w [3];
  logic [7:0] err_w [3];
  logic [7:0] err0, err1;
  logic [1:0] err2;

  assign if0.d0 = d0_r[0];
  assign if0.d1 = d1_r[0];
  assign if1.d0 = d0_r[1];
  assign if1.d1 = d1_r[1];
  assign if2.d0 = d0_r[2];
  assign if2.d1 = d1_r[2];
  assign e_w[0] = if0.e;
  assign e_w[1] = if1.e;
  assign e_w[2] = if2.e;
  assign err_w[0] = err0;
  assign err_w[1] = err1;
  assign err_w[2] = {6'd0, err2};

  dual_rail_expect_sink #(
    .SEQ_LEN(6), .EXPECT_SEQ(32'b000110), .LOOP(1'b1), .ERR_W(8)
  ) dut0 (
    .clk(clk), .reset(reset), .ch(if0), .stall(st_r[0]), .tok_valid(tv_w[0]),
    .tok_data(td_w[0]), .mismatch(mm_w[0]), .err_count(err0), .seq_idx(si_w[0]),
    .done(dn_w[0]), .overrun(ov_w[0]), .proto_err(pe_w[0])
  );

  dual_rail_expect_sink #(
    .SEQ_LEN(3), .EXPECT_SEQ(32'b010), .LOOP(1'b0), .ERR_W(8)
  ) dut1 (
    .clk(clk), .reset(reset), .ch(if1), .stall(st_r[1]), .tok_valid(tv_w[1]),
    .tok_data(td_w[1]), .mismatch(mm_w[1]), .err_count(err1), .seq_idx(si_w[1]),
    .done(dn_w[1]), .overrun(ov_w[1]), .proto_err(pe_w[1])
  );

  dual_rail_expect_sink #(
    .SEQ_LEN(1), .EXPECT_SEQ(32'b0), .LOOP(1'b1), .ERR_W(2)
  ) dut2 (
    .clk(clk), .reset(reset), .ch(if2), .stall(st_r[2]), .tok_valid(tv_w[2]),
    .tok_data(td_w[2]), .mismatch(mm_w[2]), .err_count(err2), .seq_idx(si_w[2]),
    .done(dn_w[2]), .overrun(ov_w[2]), .proto_err(pe_w[2])
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: expected sequence as a bit list, index and counters as ints.
  int          m_len [3];
  int          m_loop [3];
  int          m_errmax [3];
  logic [31:0] m_seq [3];
  int          m_idx [3];
  int          m_err [3];
  bit          m_done [3];
  bit          m_ovr [3];

  int tok_cnt [3];
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) tok_cnt[k] <= 0;
      else if (tv_w[k] === 1'b1) tok_cnt[k] <= tok_cnt[k] + 1;
    end
  end

  task automatic reset_models();
    m_len = '{6, 3, 1};
    m_loop = '{1, 0, 1};
    m_errmax = '{255, 255, 3};
    m_seq = '{32'b000110, 32'b010, 32'b0};
    for (int k = 0; k < 3; k++) begin
      m_idx[k] = 0;
      m_err[k] = 0;
      m_done[k] = 1'b0;
      m_ovr[k] = 1'b0;
    end
  endtask

  task automatic wait_e_high(input int k);
    int t = 0;
    while (e_w[k] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (e_w[k] !== 1'b1) $display("FAIL e_ready k=%0d got %b want 1", k, e_w[k]);
    else n_pass++;
  endtask

  // Full four-phase token: raise one rail, wait for e to fall, drop the rail.
  task automatic send_tok(input int k, input bit v);
    int t;
    bit exp_mm;
    wait_e_high(k);
    if (v) d1_r[k] = 1'b1;
    else d0_r[k] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (e_w[k] !== 1'b0 && t < 20);

    if (!m_loop[k] && m_idx[k] == m_len[k]) begin
      exp_mm = 1'b0;
      m_ovr[k] = 1'b1;
    end else begin
      exp_mm = (v != m_seq[k][m_idx[k]]);
      if (exp_mm && m_err[k] < m_errmax[k]) m_err[k]++;
      m_idx[k] = m_loop[k] ? (m_idx[k] + 1) % m_len[k] : m_idx[k] + 1;
      if (!m_loop[k] && m_idx[k] == m_len[k]) m_done[k] = 1'b1;
    end

    n_chk++;
    if (t != 3) $display("FAIL ack_latency k=%0d got %0d want 3", k, t);
    else n_pass++;
    n_chk++;
    if (tv_w[k] !== 1'b1) $display("FAIL tok_valid k=%0d got %b want 1", k, tv_w[k]);
    else n_pass++;
    n_chk++;
    if (td_w[k] !== v) $display("FAIL tok_data k=%0d got %b want %b", k, td_w[k], v);
    else n_pass++;
    n_chk++;
    if (mm_w[k] !== exp_mm) $display("FAIL mismatch k=%0d got %b want %b", k, mm_w[k], exp_mm);
    else n_pass++;
    n_chk++;
    if (err_w[k] !== 8'(m_err[k]))
      $display("FAIL err_count k=%0d got %0d want %0d", k, err_w[k], m_err[k]);
    else n_pass++;
    n_chk++;
    if (si_w[k] !== 5'(m_idx[k] % 32))
      $display("FAIL seq_idx k=%0d got %0d want %0d", k, si_w[k], m_idx[k] % 32);
    else n_pass++;
    n_chk++;
    if (dn_w[k] !== m_done[k] || ov_w[k] !== m_ovr[k])
      $display("FAIL done_overrun k=%0d got %b%b want %b%b", k, dn_w[k], ov_w[k],
               m_done[k], m_ovr[k]);
    else n_pass++;

    d0_r[k] = 1'b0;
    d1_r[k] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (tv_w[k] !== 1'b0 || mm_w[k] !== 1'b0)
      $display("FAIL pulse_width k=%0d got tv=%b mm=%b want 0 0", k, tv_w[k], mm_w[k]);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (e_w[k] !== 1'b0 || tv_w[k] !== 1'b0 || td_w[k] !== 1'b0 || mm_w[k] !== 1'b0 ||
          err_w[k] !== 8'd0 || si_w[k] !== 5'd0 || dn_w[k] !== 1'b0 || ov_w[k] !== 1'b0 ||
          pe_w[k] !== 1'b0)
        $display("FAIL reset_values k=%0d got e=%b tv=%b err=%0d idx=%0d want all 0",
                 k, e_w[k], tv_w[k], err_w[k], si_w[k]);
      else n_pass++;
    end
    reset = 1'b0;
    reset_models();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (e_w[k] !== (c == 3))
          $display("FAIL e_after_reset k=%0d edge=%0d got %b want %b", k, c, e_w[k], c == 3);
        else n_pass++;
      end
    end
  endtask

  task automatic test_loop_seq();
    logic [5:0] pat_a = 6'b000110;
    logic [5:0] pat_b = 6'b100110;
    int base = tok_cnt[0];
    for (int i = 0; i < 6; i++) send_tok(0, pat_a[i]);
    n_chk++;
    if (err_w[0] !== 8'd0 || si_w[0] !== 5'd0)
      $display("FAIL loop_clean got err=%0d idx=%0d want 0 0", err_w[0], si_w[0]);
    else n_pass++;
    for (int i = 0; i < 6; i++) send_tok(0, pat_b[i]);
    repeat (2) @(negedge clk);
    n_chk++;
    if (err_w[0] !== 8'd1 || si_w[0] !== 5'd0)
      $display("FAIL loop_one_err got err=%0d idx=%0d want 1 0", err_w[0], si_w[0]);
    else n_pass++;
    n_chk++;
    if (tok_cnt[0] - base != 12)
      $display("FAIL loop_tok_count got %0d want 12", tok_cnt[0] - base);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) send_tok(0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 4; i++) send_tok(1, 1'($urandom_range(0, 1)));
    n_chk++;
    if (dn_w[1] !== 1'b1 || ov_w[1] !== 1'b1)
      $display("FAIL oneshot_end got done=%b ovr=%b want 1 1", dn_w[1], ov_w[1]);
    else n_pass++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) send_tok(2, 1'b1);
    for (int i = 0; i < 3; i++) send_tok(2, 1'($urandom_range(0, 1)));
    n_chk++;
    if (err_w[2] !== 8'd3) $display("FAIL err_saturate got %0d want 3", err_w[2]);
    else n_pass++;
  endtask

  task automatic test_proto();
    int t = 0;
    int base;
    wait_e_high(0);
    base = tok_cnt[0];
    d0_r[0] = 1'b1;
    d1_r[0] = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (e_w[0] !== 1'b0 && t < 20);
    n_chk++;
    if (t != 3 || tv_w[0] !== 1'b0 || pe_w[0] !== 1'b1)
      $display("FAIL proto_detect got t=%0d tv=%b pe=%b want 3 0 1", t, tv_w[0], pe_w[0]);
    else n_pass++;
    d0_r[0] = 1'b0;
    d1_r[0] = 1'b0;
    wait_e_high(0);
    n_chk++;
    if (pe_w[0] !== 1'b1 || tok_cnt[0] != base || si_w[0] !== 5'(m_idx[0]))
      $display("FAIL proto_sticky got pe=%b toks=%0d idx=%0d want 1 %0d %0d",
               pe_w[0], tok_cnt[0] - base, si_w[0], 0, m_idx[0]);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int base;
    wait_e_high(0);
    base = tok_cnt[0];
    d0_r[0] = 1'b1;
    #2 d0_r[0] = 1'b0;
    repeat (6) @(negedge clk);
    n_chk++;
    if (e_w[0] !== 1'b1 || tok_cnt[0] != base)
      $display("FAIL glitch_ignored got e=%b toks=%0d want 1 0", e_w[0], tok_cnt[0] - base);
    else n_pass++;
  endtask

  task automatic test_stall();
    bit rose = 1'b0;
    wait_e_high(0);
    st_r[0] = 1'b1;
    send_tok(0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (e_w[0] !== 1'b0) rose = 1'b1;
    end
    n_chk++;
    if (rose) $display("FAIL stall_hold got e=1 want 0");
    else n_pass++;
    st_r[0] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (e_w[0] !== 1'b1) $display("FAIL stall_release got e=%b want 1", e_w[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit rose = 1'b0;
    int t = 0;
    wait_e_high(0);
    d1_r[0] = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    reset_models();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (e_w[0] !== 1'b0) rose = 1'b1;
    end
    n_chk++;
    if (rose) $display("FAIL reset_mid_hold got e=1 want 0");
    else n_pass++;
    n_chk++;
    if (si_w[0] !== 5'd0 || err_w[0] !== 8'd0 || pe_w[0] !== 1'b0)
      $display("FAIL reset_mid_clear got idx=%0d err=%0d pe=%b want 0 0 0",
               si_w[0], err_w[0], pe_w[0]);
    else n_pass++;
    d1_r[0] = 1'b0;
    do begin
      @(negedge clk);
      t++;
    end while (e_w[0] !== 1'b1 && t < 20);
    n_chk++;
    if (t != 3) $display("FAIL reset_mid_rise got %0d edges want 3", t);
    else n_pass++;
    send_tok(0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      d0_r[k] = 1'b0;
      d1_r[k] = 1'b0;
      st_r[k] = 1'b0;
    end
    reset_models();
    @(negedge clk);
    test_reset();
    test_loop_seq();
    test_random();
    test_saturation();
    test_proto();
    test_glitch();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dual_rail_expect_sink.md
Name: dual_rail_expect_sink

Overview:
- Clocked Verilog-side consumer of a 1-of-2 dual-rail, four-phase channel driven from prsim, e.g. the L.d[0]/L.d[1] rails with active-high enable L.e.
- Acknowledges each token, compares it against a parameterised expected-value sequence (loop or one-shot) and reports mismatches and protocol violations.
- Drop-in replacement for a prsim channel-sink plus expect checker, so mixed prsim/Verilog benches can terminate channels in RTL.

Parameters:
- SEQ_LEN, 6, number of entries in the expected sequence (1..32).
- EXPECT_SEQ, 32'b000110, expected token values; bit i is the value of token i (0 = rail d0, 1 = rail d1).
- LOOP, 1, 1 = sequence index wraps to 0 after SEQ_LEN-1; 0 = one-shot.
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high.
- d0  input  1  data rail 0, asynchronous to clk.
- d1  input  1  data rail 1, asynchronous to clk.
- stall  input  1  when 1, holds off re-raising the enable.
- e  output  1  channel enable/acknowledge, active-high (1 = ready for data).
- tok_valid  output  1  one-cycle pulse per accepted token.
- tok_data  output  1  value of the last accepted token.
- mismatch  output  1  one-cycle pulse, coincident with tok_valid, when the token differs from the expected value.
- err_count  output  ERR_W  saturating count of mismatches.
- seq_idx  output  5  index of the next expected token.
- done  output  1  one-shot mode only: all SEQ_LEN tokens received.
- overrun  output  1  sticky: token received after done.
- proto_err  output  1  sticky: both rails seen high simultaneously.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Synchronisation: d0 and d1 each pass through a 2-flop synchroniser; all FSM decisions use the synchronised s0/s1. Flop contents are cleared on reset.
- Reset values: e=0, tok_valid=0, tok_data=0, mismatch=0, err_count=0, seq_idx=0, done=0, overrun=0, proto_err=0. FSM enters WAIT_NEUTRAL.
- WAIT_NEUTRAL (e=0):
  - Stays here until s0=0, s1=0 and stall=0.
  - Then registers e=1 and moves to READY.
  - A reset asserted mid-handshake therefore always drains to neutral before the next token.
- READY (e=1):
  - s0 xor s1 = 1: on that edge, e goes to 0, tok_valid pulses, tok_data=s1, and mismatch is computed against EXPECT_SEQ[seq_idx]. seq_idx then advances; FSM moves to WAIT_NEUTRAL.
  - s0=s1=1: proto_err is set, e goes to 0, no token is counted, FSM moves to WAIT_NEUTRAL.
- Latency: an input rail rise is synchronised after 2 edges; e falls and tok_valid pulses on the 3rd edge. Neutral-to-e-rise is likewise 3 edges when stall=0.
- Stall: sampled only in WAIT_NEUTRAL; stall=1 keeps e=0 indefinitely. stall has no effect in READY.
- Sequence index:
  - LOOP=1: seq_idx increments modulo SEQ_LEN.
  - LOOP=0: seq_idx stops at SEQ_LEN and done is set on the edge that accepts token SEQ_LEN-1. Further tokens are still acknowledged, but they set overrun and are not compared (mismatch=0).
- err_count: increments on each mismatch and saturates at 2^ERR_W-1. It never wraps.
- Simultaneous events: reset has priority over everything, including an accept on the same edge.
- Rail glitches that return to neutral before synchronisation are not counted.

Decomposition:
- Shared package (e.g. dual_rail_pkg) holds:
  - the FSM state enum (WAIT_NEUTRAL, READY);
  - rail-encoding constants (RAIL_0=0, RAIL_1=1);
  - the enable-polarity constant E_ACTIVE=1, for reuse by the matching dual_rail_source.
- One sub-module, sync2, a 2-flop synchroniser with synchronous reset, instantiated once per rail.

Test Plan:
- Reset then release, rails neutral, stall=0: e=0 during reset and rises on the 3rd edge after reset drops. All counters are 0.
- LOOP=1, EXPECT_SEQ=000110, drive the tokens 0,1,1,0,0,0 with a four-phase source: six tok_valid pulses, mismatch never asserted, err_count=0, seq_idx back at 0.
- Same setup, but drive 0,1,1,0,0,1 instead: a single mismatch pulse on the 6th token, err_count=1, seq_idx=0.
- LOOP=0, SEQ_LEN=3, drive 4 tokens: done=1 after the 3rd token. The 4th token is acknowledged with overrun=1 and mismatch=0.
- Raise d0 and d1 together while in READY: proto_err=1, e falls, no tok_valid. After both rails return low, e rises again; proto_err stays 1.
- Hold stall=1 after a token and drop the rails: e stays 0 for the whole stall. It rises 1 edge after stall drops, since the rails are already synchronised low. Separately, assert reset mid-token with d1 still high: e=0, and e rises only after d1 falls.
